// File: rtl/ctrl_step_sequencer_if.sv
// Handshake/control bundle between the opcode source and ctrl_step_sequencer.
// master drives run/ir_opcode; slave (the sequencer) drives the strobes and status.
interface ctrl_step_sequencer_if #(
    parameter int STEP_W   = 4,
    parameter int OPCODE_W = 5
);
    logic                run;
    logic [OPCODE_W-1:0] ir_opcode;
    logic [19:0]         ctrl;
    logic [STEP_W-1:0]   step;
    logic                busy;
    logic                done;
    logic                err;
    logic [31:0]         instr_count;

    modport master (
        output run, ir_opcode,
        input  ctrl, step, busy, done, err, instr_count
    );

    modport slave (
        input  run, ir_opcode,
        output ctrl, step, busy, done, err, instr_count
    );
endinterface

// File: rtl/ctrl_step_sequencer.sv
// Moore T-step sequencer driving DataPath strobes for ld/ldi/st/addi.
// Define SEQ_INSTR_COUNT_EN to build the saturating completed-instruction counter.
module ctrl_step_sequencer #(
    parameter int STEP_W   = 4,
    parameter int MEM_WAIT = 0,
    parameter int OPCODE_W = 5
) (
    input logic                  clock,
    input logic                  clear,
    ctrl_step_sequencer_if.slave bus
);
    localparam int PC_OUT = 0,  MAR_IN = 1,  INC_PC = 2,   ZLOW_IN = 3,  ZLOW_OUT = 4;
    localparam int PC_IN  = 5,  READ   = 6,  MD_READ = 7,  MDR_IN = 8,   MDR_OUT = 9;
    localparam int IR_IN  = 10, GRA    = 11, GRB    = 12,  R_IN   = 13,  R_OUT   = 14;
    localparam int BA_OUT = 15, Y_IN   = 16, CSIGN_OUT = 17, ADD  = 18,  WRITE   = 19;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       err_q;

    logic is_ld, is_ldi, is_st, is_addi, legal;
    assign is_ld   = (bus.ir_opcode == OPCODE_W'(0));
    assign is_ldi  = (bus.ir_opcode == OPCODE_W'(1));
    assign is_st   = (bus.ir_opcode == OPCODE_W'(2));
    assign is_addi = (bus.ir_opcode == OPCODE_W'(3));
    assign legal   = is_ld | is_ldi | is_st | is_addi;

    logic [19:0]       ctrl_c;
    logic [STEP_W-1:0] step_c;
    logic              busy_c, mem_step, final_step, done_c;

    // Strobes depend only on the registered state and the IR opcode, never on run.
    always_comb begin
        ctrl_c     = '0;
        step_c     = '0;
        busy_c     = 1'b1;
        mem_step   = 1'b0;
        final_step = 1'b0;
        case (state)
            S_T0: begin
                step_c = STEP_W'(0);
                ctrl_c[PC_OUT] = 1'b1; ctrl_c[MAR_IN] = 1'b1;
                ctrl_c[INC_PC] = 1'b1; ctrl_c[ZLOW_IN] = 1'b1;
            end
            S_T1: begin
                step_c = STEP_W'(1); mem_step = 1'b1;
                ctrl_c[ZLOW_OUT] = 1'b1; ctrl_c[PC_IN] = 1'b1; ctrl_c[READ] = 1'b1;
                ctrl_c[MD_READ] = 1'b1; ctrl_c[MDR_IN] = 1'b1;
            end
            S_T2: begin
                step_c = STEP_W'(2);
                ctrl_c[MDR_OUT] = 1'b1; ctrl_c[IR_IN] = 1'b1;
            end
            S_T3: begin
                step_c = STEP_W'(3);
                if (is_ld || is_ldi || is_st) begin
                    ctrl_c[GRB] = 1'b1; ctrl_c[BA_OUT] = 1'b1; ctrl_c[Y_IN] = 1'b1;
                end else if (is_addi) begin
                    ctrl_c[GRB] = 1'b1; ctrl_c[R_OUT] = 1'b1; ctrl_c[Y_IN] = 1'b1;
                end
            end
            S_T4: begin
                step_c = STEP_W'(4);
                ctrl_c[CSIGN_OUT] = 1'b1; ctrl_c[ADD] = 1'b1; ctrl_c[ZLOW_IN] = 1'b1;
            end
            S_T5: begin
                step_c = STEP_W'(5);
                ctrl_c[ZLOW_OUT] = 1'b1;
                if (is_ld || is_st) begin
                    ctrl_c[MAR_IN] = 1'b1;
                end else begin
                    ctrl_c[GRA] = 1'b1; ctrl_c[R_IN] = 1'b1;
                end
                final_step = is_ldi | is_addi;
            end
            S_T6: begin
                step_c = STEP_W'(6);
                if (is_ld) begin
                    mem_step = 1'b1;
                    ctrl_c[READ] = 1'b1; ctrl_c[MD_READ] = 1'b1; ctrl_c[MDR_IN] = 1'b1;
                end else begin
                    ctrl_c[GRA] = 1'b1; ctrl_c[BA_OUT] = 1'b1; ctrl_c[MDR_IN] = 1'b1;
                end
            end
            S_T7: begin
                step_c = STEP_W'(7); final_step = 1'b1;
                if (is_st) begin
                    mem_step = 1'b1;
                    ctrl_c[WRITE] = 1'b1;
                end else begin
                    ctrl_c[MDR_OUT] = 1'b1; ctrl_c[GRA] = 1'b1; ctrl_c[R_IN] = 1'b1;
                end
            end
            default: busy_c = 1'b0;
        endcase
        done_c = final_step & (~mem_step | (wait_cnt == 4'd0));
    end

    // Memory steps: counter loaded on entry, step advances once it reaches zero.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.run) state <= S_T0;
                S_T0: begin
                    state    <= S_T1;
                    wait_cnt <= WAIT_INIT;
                end
                S_T1: begin
                    if (wait_cnt == 4'd0) state <= S_T2;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    if (legal) begin
                        state <= S_T4;
                    end else begin
                        state <= S_HALT;
                        err_q <= 1'b1;
                    end
                end
                S_T4: state <= S_T5;
                S_T5: begin
                    if (is_ldi || is_addi) begin
                        state <= bus.run ? S_T0 : S_IDLE;
                    end else begin
                        state <= S_T6;
                        if (is_ld) wait_cnt <= WAIT_INIT;
                    end
                end
                S_T6: begin
                    if (is_ld) begin
                        if (wait_cnt == 4'd0) state <= S_T7;
                        else                  wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state    <= S_T7;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                S_T7: begin
                    if (is_st && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                    else                           state <= bus.run ? S_T0 : S_IDLE;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ctrl = ctrl_c;
    assign bus.step = step_c;
    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.err  = err_q;

`ifdef SEQ_INSTR_COUNT_EN
    logic [31:0] count_q;
    always_ff @(posedge clock or posedge clear) begin
        if (clear)                           count_q <= '0;
        else if (done_c && count_q != '1)    count_q <= count_q + 32'd1;
    end
    assign bus.instr_count = count_q;
`else
    assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Scoreboard bench for ctrl_step_sequencer: expected per-cycle T-step traces are queued
// at issue time and a negedge monitor pops one entry for every busy cycle.
module tb_ctrl_step_sequencer;
    localparam int MW = 2;

    typedef struct packed {
        logic [3:0]  step;
        logic [19:0] ctrl;
        logic        done;
    } exp_t;

    logic clock = 1'b0;
    logic clear;

    ctrl_step_sequencer_if #(.STEP_W(4), .OPCODE_W(5)) bus();
    ctrl_step_sequencer #(.STEP_W(4), .MEM_WAIT(MW), .OPCODE_W(5)) dut (
        .clock(clock), .clear(clear), .bus(bus.slave)
    );

    always #5 clock = ~clock;

    exp_t sb[$];
    int   done_cyc[$];
    int   n_vec = 0, n_err = 0, cyc = 0, exp_cnt = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int step, input logic [19:0] c, input bit d, input int reps);
        exp_t e;
        for (int i = 0; i < reps; i++) begin
            e.step = 4'(step); e.ctrl = c; e.done = d;
            sb.push_back(e);
        end
    endtask

    task automatic push_fetch();
        push(0, 20'h0000F, 1'b0, 1);
        push(1, 20'h001F0, 1'b0, MW + 1);
        push(2, 20'h00600, 1'b0, 1);
    endtask

    task automatic push_ld();
        push_fetch();
        push(3, 20'h19000, 1'b0, 1);
        push(4, 20'h60008, 1'b0, 1);
        push(5, 20'h00012, 1'b0, 1);
        push(6, 20'h001C0, 1'b0, MW + 1);
        push(7, 20'h02A00, 1'b1, 1);
    endtask

    task automatic push_st();
        push_fetch();
        push(3, 20'h19000, 1'b0, 1);
        push(4, 20'h60008, 1'b0, 1);
        push(5, 20'h00012, 1'b0, 1);
        push(6, 20'h08900, 1'b0, 1);
        push(7, 20'h80000, 1'b0, MW);
        push(7, 20'h80000, 1'b1, 1);
    endtask

    task automatic push_ldi();
        push_fetch();
        push(3, 20'h19000, 1'b0, 1);
        push(4, 20'h60008, 1'b0, 1);
        push(5, 20'h02810, 1'b1, 1);
    endtask

    task automatic push_addi();
        push_fetch();
        push(3, 20'h15000, 1'b0, 1);
        push(4, 20'h60008, 1'b0, 1);
        push(5, 20'h02810, 1'b1, 1);
    endtask

    task automatic issue(input logic [4:0] op);
        @(negedge clock);
        bus.ir_opcode = op;
        bus.run = 1'b1;
        @(negedge clock);
        bus.run = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || bus.busy !== 1'b0) && k < 300) begin
            @(negedge clock); #1; k++;
        end
        chk({"drain_", name}, 64'(k < 300), 64'(1));
        chk({"queue_empty_", name}, 64'(sb.size()), 64'(0));
    endtask

    task automatic bump();
`ifdef SEQ_INSTR_COUNT_EN
        exp_cnt++;
`endif
    endtask

    // Monitor: one scoreboard entry per busy cycle, idle cycles must be quiet.
    always @(negedge clock) begin
        exp_t e;
        if (clear === 1'b0) begin
            if (bus.busy === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_busy: step %0d ctrl %0h, expected idle", bus.step, bus.ctrl);
                end else begin
                    e = sb.pop_front();
                    chk("step", 64'(bus.step), 64'(e.step));
                    chk("ctrl", 64'(bus.ctrl), 64'(e.ctrl));
                    chk("done", 64'(bus.done), 64'(e.done));
                end
                if (bus.done === 1'b1) done_cyc.push_back(cyc);
            end else begin
                chk("idle_done", 64'(bus.done), 64'(0));
                chk("idle_step", 64'(bus.step), 64'(0));
                chk("idle_ctrl", 64'(bus.ctrl), 64'(0));
            end
        end
    end

    task automatic chk_zero(input string tag, input logic exp_err);
        chk({tag, "_ctrl"},  64'(bus.ctrl), 64'(0));
        chk({tag, "_step"},  64'(bus.step), 64'(0));
        chk({tag, "_busy"},  64'(bus.busy), 64'(0));
        chk({tag, "_done"},  64'(bus.done), 64'(0));
        chk({tag, "_err"},   64'(bus.err),  64'(exp_err));
        chk({tag, "_count"}, 64'(bus.instr_count), 64'(exp_cnt));
    endtask

    initial begin
        int k;
        clear = 1'b1;
        bus.run = 1'b0;
        bus.ir_opcode = 5'd0;
        #12;
        chk_zero("reset", 1'b0);
        @(negedge clock);
        clear = 1'b0;

        // ld, run pulsed for one cycle
        push_ld(); issue(5'd0); drain("ld"); bump();
        chk_zero("after_ld", 1'b0);

        // st: Write only in T7, MD_read low in T6
        push_st(); issue(5'd2); drain("st"); bump();
        chk("st_count", 64'(bus.instr_count), 64'(exp_cnt));

        push_ldi(); issue(5'd1); drain("ldi"); bump();

        // two addi back to back with run held
        done_cyc.delete();
        push_addi(); push_addi();
        @(negedge clock);
        bus.ir_opcode = 5'd3;
        bus.run = 1'b1;
        k = 0;
        while (done_cyc.size() < 1 && k < 100) begin @(negedge clock); #1; k++; end
        chk("b2b_first_done", 64'(k < 100), 64'(1));
        @(posedge clock); #1;
        bus.run = 1'b0;
        drain("addi_b2b"); bump(); bump();
        chk("b2b_done_count", 64'(done_cyc.size()), 64'(2));
        if (done_cyc.size() == 2)
            chk("b2b_done_gap", 64'(done_cyc[1] - done_cyc[0]), 64'(6 + MW));
        chk("b2b_instr_count", 64'(bus.instr_count), 64'(exp_cnt));

        // illegal opcode: HALT with sticky err, run ignored
        push_fetch(); push(3, 20'h0, 1'b0, 1);
        issue(5'h1F); drain("illegal");
        chk_zero("halt", 1'b1);
        @(negedge clock);
        bus.run = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        chk_zero("halt_run", 1'b1);
        bus.run = 1'b0;

        // clear leaves HALT
        @(negedge clock); clear = 1'b1; exp_cnt = 0;
        #1; chk_zero("clear_halt", 1'b0);
        @(negedge clock); clear = 1'b0;

        // clear in the middle of the T6 wait of ld
        push_ld(); issue(5'd0);
        k = 0;
        do begin @(posedge clock); #2; k++; end while (bus.step !== 4'd6 && k < 50);
        chk("reach_t6", 64'(bus.step), 64'(6));
        #1; clear = 1'b1;
        #1; exp_cnt = 0;
        chk_zero("clear_mid_wait", 1'b0);
        sb.delete();
        @(negedge clock); clear = 1'b0;

        push_ldi(); issue(5'd1); drain("restart_ldi"); bump();
        chk_zero("final", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ctrl_step_sequencer.md
# ctrl_step_sequencer

Hardwired control-step sequencer for the DataPath. It replaces hand-driven T-state stimulus with a synthesizable Moore FSM that produces fetch and execute control strobes for `ld`, `ldi`, `st` and `addi`. Memory wait states are parametrised, and back-to-back instruction issue is supported. It sits between the instruction register opcode field and the DataPath control inputs.

## Interface
- `STEP_W`, 4, width of `step` output; must be ≥3.
- `MEM_WAIT`, 0, extra cycles each memory step (Read or Write) is held; 0..15.
- `OPCODE_W`, 5, width of opcode field (IR[31:27]).

Ports:
- `clock`  in  1  system clock, rising edge active.
- `clear`  in  1  asynchronous, active-high reset.
- `run`  in  1  level request to execute instructions.
- `ir_opcode`  in  OPCODE_W  opcode from IR; sampled from T3 onward.
- `ctrl`  out  20  strobes: [0]PCout [1]MARin [2]IncPC [3]Zlowin [4]Zlowout [5]PCin [6]Read [7]MD_read [8]MDRin [9]MDRout [10]IRin [11]Gra [12]Grb [13]Rin [14]Rout [15]BAout [16]Yin [17]Csignout [18]ADD [19]Write.
- `step`  out  STEP_W  current T-step number (0 in IDLE/HALT).
- `busy`  out  1  high in any T-step.
- `done`  out  1  high in last cycle of an instruction's final step.
- `err`  out  1  sticky illegal-opcode flag.
- `instr_count`  out  32  completed-instruction count (see Configuration).

## Operation
- States: IDLE, T0–T7, HALT. IDLE→T0 when `run`=1.
- Fetch, common to all opcodes:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MD_read, MDRin (memory step).
  - T2: MDRout, IRin.
- T3 decodes `ir_opcode`:
  - `ld` 00000: T3 Grb,BAout,Yin; T4 Csignout,ADD,Zlowin; T5 Zlowout,MARin; T6 Read,MD_read,MDRin (memory step); T7 MDRout,Gra,Rin. Final step T7.
  - `ldi` 00001: T3, T4 as `ld`; T5 Zlowout,Gra,Rin. Final step T5.
  - `st` 00010: T3–T5 as `ld`; T6 Gra,BAout,MDRin (MD_read=0); T7 Write (memory step). Final step T7.
  - `addi` 00011: T3 Grb,Rout,Yin; T4 Csignout,ADD,Zlowin; T5 Zlowout,Gra,Rin. Final step T5.
  - Any other opcode: `ctrl`=0 in T3, next state HALT, `err` set. HALT is left only via `clear`; `run` is ignored in HALT.
- At the end of the final step:
  - `run`=1 → T0 directly, with no IDLE bubble.
  - `run`=0 → IDLE.
- `run` falling mid-instruction does not abort; the instruction completes.
- Memory step: internal wait counter loads MEM_WAIT on entry and decrements each cycle. The step advances when the counter is 0. `ctrl` and `step` are held constant throughout.
- `ctrl`, `step`, `busy` and `done` are decoded from registered state plus `ir_opcode` only; `run` never drives them combinationally.

## Timing
- Non-memory step: exactly 1 cycle. Memory step: MEM_WAIT+1 cycles.
- Fetch: 3+MEM_WAIT cycles.
- Instruction length: `ld` and `st` take 8+2·MEM_WAIT cycles; `ldi` and `addi` take 6+MEM_WAIT.
- First T0 is the cycle after `run` is sampled high in IDLE.
- `done`: exactly one cycle per instruction, coincident with the last cycle of the final step.
- `clear`: asynchronously forces IDLE. All outputs go to 0, including `ctrl`, `step`, `busy`, `done`, `err` and `instr_count`; the wait counter also resets. This applies mid-step and mid-wait. First T0 may follow on the first rising edge after `clear` deasserts, if `run`=1.

## Configuration
- `SEQ_INSTR_COUNT_EN` defined:
  - `instr_count` increments on every cycle where `done`=1.
  - It saturates at 32'hFFFF_FFFF and clears only on `clear`.
- Undefined: counter logic is omitted and `instr_count` is tied to 0. All other behaviour is identical.

## Test plan
- MEM_WAIT=0, `run` pulsed 1 cycle, opcode 00000 → T0..T7 with strobes exactly as listed; `done` in 8th busy cycle; then IDLE, `busy`=0.
- MEM_WAIT=2, `ld` → Read/MD_read/MDRin high 3 cycles in T1 and 3 in T6; `step` held; 12 busy cycles total.
- `run` held, two `addi` → T5 of first followed directly by T0; `done` pulses 6 cycles apart; `instr_count`=2 with macro, 0 without.
- `st`, MEM_WAIT=1 → ctrl[19] high only in T7 for 2 cycles; MD_read=0 in T6.
- Opcode 11111 → `ctrl`=0 in T3, HALT, `err`=1; `run`=1 produces no T0 until `clear`.
- `clear` asserted in T6 wait of `ld` (MEM_WAIT=3) → all outputs 0 before next edge; restart with `run`=1 yields a clean T0.
